sr_flag_bank: RTL and testbench

- Clocked, parametrised successor to the gate-level cross-coupled NOR SR latch.
- Provides N independent synchronous SR flag registers.
- Adds a selectable policy for simultaneous set/clear, which gives that condition defined behaviour.
- Adds per-channel post-change lockout (debounce), registered edge pulses, and sticky conflict reporting.
- Used wherever status/event flags are raised and cleared by separate agents.

---
 rtl/sr_flag_bank.sv | 126 ++++++++++++
 tb/tb_sr_flag_bank.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sr_flag_bank.sv
// Bank of N independent synchronous set/reset flags with a selectable set+clear policy,
// per-channel post-change lockout, registered edge pulses and sticky conflict reporting.
module sr_flag_bank #(
    parameter int unsigned    N    = 4,
    parameter int unsigned    MODE = 0,
    parameter int unsigned    LOCK = 0,
    parameter logic [N-1:0]   INIT = '0,
    parameter int unsigned    CW   = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  set,
    input  logic [N-1:0]  clr,
    input  logic [N-1:0]  conflict_clr,
    output logic [N-1:0]  q,
    output logic [N-1:0]  q_bar,
    output logic [N-1:0]  rise,
    output logic [N-1:0]  fall,
    output logic [N-1:0]  locked,
    output logic [N-1:0]  conflict,
    output logic [CW-1:0] conflict_cnt
);

    // Outcome of a simultaneous set and clear for a flag whose current value is cur.
    function automatic logic resolve_conflict(input logic cur);
        case (MODE)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return cur;
            default: return ~cur;
        endcase
    endfunction

    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  q_bar_q;
    logic [N-1:0]  rise_q, rise_d;
    logic [N-1:0]  fall_q, fall_d;
    logic [N-1:0]  conflict_q, conflict_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  chg;
    logic [N-1:0]  lk_busy;
    logic [N-1:0]  both;

    assign both = set & clr;

    always_comb begin
        q_d = q_q;
        for (int i = 0; i < int'(N); i++) begin
            if (!lk_busy[i]) begin
                case ({set[i], clr[i]})
                    2'b10:   q_d[i] = 1'b1;
                    2'b01:   q_d[i] = 1'b0;
                    2'b11:   q_d[i] = resolve_conflict(q_q[i]);
                    default: q_d[i] = q_q[i];
                endcase
            end
        end
        chg        = q_d ^ q_q;
        rise_d     = chg & q_d;
        fall_d     = chg & ~q_d;
        // A fresh conflict outranks a clear request on the same edge.
        conflict_d = (conflict_q & ~conflict_clr) | both;
        cnt_d      = cnt_q;
        if ((|both) && (cnt_q != {CW{1'b1}})) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q        <= INIT;
            q_bar_q    <= ~INIT;
            rise_q     <= '0;
            fall_q     <= '0;
            conflict_q <= '0;
            cnt_q      <= '0;
        end else begin
            q_q        <= q_d;
            q_bar_q    <= ~q_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            conflict_q <= conflict_d;
            cnt_q      <= cnt_d;
        end
    end

    // Lockout: reload on every change, count down otherwise; requests ignored while nonzero.
    if (LOCK > 0) begin : g_lock
        localparam int unsigned LW = $clog2(LOCK + 1);
        logic [LW-1:0] lk_q [N];
        logic [LW-1:0] lk_d [N];

        always_comb begin
            for (int i = 0; i < int'(N); i++) begin
                lk_d[i] = lk_q[i];
                if (chg[i]) begin
                    lk_d[i] = LW'(LOCK);
                end else if (lk_q[i] != '0) begin
                    lk_d[i] = lk_q[i] - LW'(1);
                end
                lk_busy[i] = (lk_q[i] != '0);
            end
        end

        always_ff @(posedge clk) begin
            for (int i = 0; i < int'(N); i++) begin
                if (reset) begin
                    lk_q[i] <= '0;
                end else begin
                    lk_q[i] <= lk_d[i];
                end
            end
        end
    end else begin : g_nolock
        assign lk_busy = '0;
    end

    assign q            = q_q;
    assign q_bar        = q_bar_q;
    assign rise         = rise_q;
    assign fall         = fall_q;
    assign locked       = lk_busy;
    assign conflict     = conflict_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_sr_flag_bank.sv
// Directed bench for sr_flag_bank: six configurations share one stimulus stream,
// expectations are queued when inputs are driven and drained one edge later.
module tb_sr_flag_bank;

    localparam int NDUT = 6;
    localparam int F_Q = 0, F_QB = 1, F_RISE = 2, F_FALL = 3, F_LK = 4, F_CF = 5, F_CNT = 6;

    logic       clk;
    logic       reset;
    logic [3:0] set, clr, conflict_clr;

    logic [3:0] q_o    [NDUT];
    logic [3:0] qb_o   [NDUT];
    logic [3:0] rise_o [NDUT];
    logic [3:0] fall_o [NDUT];
    logic [3:0] lk_o   [NDUT];
    logic [3:0] cf_o   [NDUT];
    logic [7:0] cnt_o  [NDUT];

    // dut0..3: MODE 0..3; dut4: MODE 0 with LOCK=3; dut5: MODE 0 with CW=2.
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int CWG = (g == 5) ? 2 : 8;
        logic [CWG-1:0] cnt_w;
        sr_flag_bank #(
            .N    (4),
            .MODE ((g < 4) ? g : 0),
            .LOCK ((g == 4) ? 3 : 0),
            .INIT (4'b0101),
            .CW   (CWG)
        ) u_dut (
            .clk          (clk),
            .reset        (reset),
            .set          (set),
            .clr          (clr),
            .conflict_clr (conflict_clr),
            .q            (q_o[g]),
            .q_bar        (qb_o[g]),
            .rise         (rise_o[g]),
            .fall         (fall_o[g]),
            .locked       (lk_o[g]),
            .conflict     (cf_o[g]),
            .conflict_cnt (cnt_w)
        );
        assign cnt_o[g] = 8'(cnt_w);
    end

    typedef struct {
        string      tag;
        int         id;
        int         fld;
        logic [7:0] exp;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] observe(input int id, input int fld);
        case (fld)
            F_Q:     return {4'b0, q_o[id]};
            F_QB:    return {4'b0, qb_o[id]};
            F_RISE:  return {4'b0, rise_o[id]};
            F_FALL:  return {4'b0, fall_o[id]};
            F_LK:    return {4'b0, lk_o[id]};
            F_CF:    return {4'b0, cf_o[id]};
            default: return cnt_o[id];
        endcase
    endfunction

    task automatic push(input string tag, input int id, input int fld, input logic [7:0] e);
        sbq.push_back('{tag, id, fld, e});
    endtask

    task automatic drive(input logic r, input logic [3:0] s, input logic [3:0] c, input logic [3:0] cc);
        reset        = r;
        set          = s;
        clr          = c;
        conflict_clr = cc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        while (sbq.size() > 0) begin
            exp_t       e;
            logic [7:0] o;
            e = sbq.pop_front();
            o = observe(e.id, e.fld);
            checks++;
            assert (o === e.exp) else begin
                errors++;
                $error("FAIL %s dut%0d observed=%0h expected=%0h", e.tag, e.id, o, e.exp);
            end
        end
    endtask

    task automatic reset2();
        drive(1'b1, 4'h0, 4'h0, 4'h0);
        tick();
        tick();
    endtask

    initial begin
        drive(1'b1, 4'h0, 4'h0, 4'h0);

        // Reset values and a single set pulse
        tick();
        drive(1'b1, 4'h0, 4'h0, 4'h0);
        push("rst_q", 0, F_Q, 8'h5);
        push("rst_qb", 0, F_QB, 8'hA);
        push("rst_rise", 0, F_RISE, 8'h0);
        push("rst_fall", 0, F_FALL, 8'h0);
        push("rst_lk", 0, F_LK, 8'h0);
        push("rst_cf", 0, F_CF, 8'h0);
        push("rst_cnt", 0, F_CNT, 8'h0);
        push("rst_lk4", 4, F_LK, 8'h0);
        tick();
        drive(1'b0, 4'b0010, 4'h0, 4'h0);
        push("set_q", 0, F_Q, 8'h7);
        push("set_qb", 0, F_QB, 8'h8);
        push("set_rise", 0, F_RISE, 8'h2);
        push("set_fall", 0, F_FALL, 8'h0);
        tick();
        drive(1'b0, 4'h0, 4'h0, 4'h0);
        push("hold_q", 0, F_Q, 8'h7);
        push("rise_one", 0, F_RISE, 8'h0);
        tick();

        // Simultaneous set+clr on ch0 across all modes
        reset2();
        drive(1'b0, 4'b0001, 4'b0001, 4'h0);
        push("m0_q", 0, F_Q, 8'h4);
        push("m0_fall", 0, F_FALL, 8'h1);
        push("m1_q", 1, F_Q, 8'h5);
        push("m1_rise", 1, F_RISE, 8'h0);
        push("m1_fall", 1, F_FALL, 8'h0);
        push("m2_q", 2, F_Q, 8'h5);
        push("m2_fall", 2, F_FALL, 8'h0);
        push("m3_q", 3, F_Q, 8'h4);
        push("m3_fall", 3, F_FALL, 8'h1);
        for (int d = 0; d < 4; d++) begin
            push("mode_cf", d, F_CF, 8'h1);
            push("mode_cnt", d, F_CNT, 8'h1);
        end
        push("lk_after_chg", 4, F_LK, 8'h1);
        tick();
        drive(1'b0, 4'h0, 4'h0, 4'h0);
        push("cf_sticky", 0, F_CF, 8'h1);
        push("m0_hold", 0, F_Q, 8'h4);
        push("fall_one", 0, F_FALL, 8'h0);
        tick();

        // Toggle mode held, and counter saturation at CW=2
        reset2();
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 4'b0001, 4'b0001, 4'h0);
            if (k < 4) begin
                push("tog_q", 3, F_Q, (k % 2 == 0) ? 8'h4 : 8'h5);
                push("tog_fall", 3, F_FALL, (k % 2 == 0) ? 8'h1 : 8'h0);
                push("tog_rise", 3, F_RISE, (k % 2 == 0) ? 8'h0 : 8'h1);
                push("tog_cnt", 3, F_CNT, 8'(k + 1));
            end
            push("sat_cnt", 5, F_CNT, (k < 3) ? 8'(k + 1) : 8'h3);
            tick();
        end
        drive(1'b0, 4'b0001, 4'b0001, 4'b0001);
        push("cf_set_wins", 5, F_CF, 8'h1);
        push("sat_hold", 5, F_CNT, 8'h3);
        tick();
        drive(1'b0, 4'h0, 4'h0, 4'b0001);
        push("cf_cleared", 5, F_CF, 8'h0);
        push("cnt_keep", 5, F_CNT, 8'h3);
        tick();

        // Lockout of 3 cycles on ch1
        reset2();
        drive(1'b0, 4'b0010, 4'h0, 4'h0);
        push("lk_set_q", 4, F_Q, 8'h7);
        push("lk_set_rise", 4, F_RISE, 8'h2);
        push("lk_set_lk", 4, F_LK, 8'h2);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 4'h0, 4'b0010, 4'h0);
            push("lk_ign_q", 4, F_Q, 8'h7);
            push("lk_ign_lk", 4, F_LK, (k < 2) ? 8'h2 : 8'h0);
            push("lk_ign_fall", 4, F_FALL, 8'h0);
            tick();
        end
        drive(1'b0, 4'h0, 4'b0010, 4'h0);
        push("lk_clr_q", 4, F_Q, 8'h5);
        push("lk_clr_fall", 4, F_FALL, 8'h2);
        push("lk_clr_lk", 4, F_LK, 8'h2);
        tick();

        // Reset in the middle of a lockout with a set request present
        reset2();
        drive(1'b0, 4'b0010, 4'h0, 4'h0);
        push("mid_q", 4, F_Q, 8'h7);
        push("mid_lk", 4, F_LK, 8'h2);
        tick();
        drive(1'b1, 4'b0010, 4'h0, 4'h0);
        push("rstlk_q", 4, F_Q, 8'h5);
        push("rstlk_lk", 4, F_LK, 8'h0);
        push("rstlk_rise", 4, F_RISE, 8'h0);
        tick();
        drive(1'b0, 4'h0, 4'h0, 4'h0);
        push("post_q", 4, F_Q, 8'h5);
        push("post_rise", 4, F_RISE, 8'h0);
        push("post_lk", 4, F_LK, 8'h0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
